// File: rtl/outmem_sequencer.sv
// rtl/outmem_sequencer.sv - Output Memory port sequencer: init fill, core pass-through, streamed dump
//
// Purpose:
//   Owns the single read and single write port of the Output Memory for one
//   Bellman-Ford run. Fills DEPTH words with INIT_VAL, hands both ports to the
//   bellmanford core until it reports Finish or NegCycle, then streams the
//   final memory contents out over a valid/ready interface.
//
// Ports:
//   clock, reset                     rising-edge clock, async active-low reset
//   start                            begin a run (honoured in IDLE/DONE only)
//   core_go                          core enable, high only while the core owns memory
//   core_Finish, core_NegCycle       core completion / negative-cycle flags
//   core_OMWE/OMWAR/OMWDR/OMAR       core-side memory requests
//   core_OMDR                        read data returned to the core
//   OMWE/OMWAR/OMWDR/OMAR, OMDR      Output Memory ports (combinational read)
//   dump_valid/ready/addr/data       dump stream
//   busy, done, neg_flag             status

module outmem_sequencer #(
    parameter int                ADDR_W   = 13,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 8192,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              core_go,
    input  logic              core_Finish,
    input  logic              core_NegCycle,
    input  logic              core_OMWE,
    input  logic [ADDR_W-1:0] core_OMWAR,
    input  logic [DATA_W-1:0] core_OMWDR,
    input  logic [ADDR_W-1:0] core_OMAR,
    output logic [DATA_W-1:0] core_OMDR,
    output logic              OMWE,
    output logic [ADDR_W-1:0] OMWAR,
    output logic [DATA_W-1:0] OMWDR,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              neg_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    // One extra counter bit lets DEPTH == 2**ADDR_W be represented.
    localparam int               LAST_INT = DEPTH - 1;
    localparam logic [ADDR_W:0]  LAST_IDX = LAST_INT[ADDR_W:0];
    localparam logic [ADDR_W:0]  CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                end
            end
            S_INIT: begin
                // Exactly DEPTH write cycles: leave on the edge that writes the last word.
                if (cnt_q == LAST_IDX) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                // A negative cycle wins over a simultaneous Finish and skips the dump.
                if (core_NegCycle) begin
                    state_d = S_DONE;
                    neg_d   = 1'b1;
                end else if (core_Finish) begin
                    state_d = S_DUMP;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs; RUN is a straight pass-through of the core's requests.
    always_comb begin
        core_go    = 1'b0;
        OMWE       = 1'b0;
        OMWAR      = '0;
        OMWDR      = '0;
        OMAR       = '0;
        dump_valid = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_INIT: begin
                busy  = 1'b1;
                OMWE  = 1'b1;
                OMWAR = cnt_q[ADDR_W-1:0];
                OMWDR = INIT_VAL;
            end
            S_RUN: begin
                busy    = 1'b1;
                core_go = 1'b1;
                OMWE    = core_OMWE;
                OMWAR   = core_OMWAR;
                OMWDR   = core_OMWDR;
                OMAR    = core_OMAR;
            end
            S_DUMP: begin
                // Write port stays closed so a late core write cannot disturb the dump.
                busy       = 1'b1;
                OMAR       = cnt_q[ADDR_W-1:0];
                dump_valid = 1'b1;
                dump_addr  = cnt_q[ADDR_W-1:0];
                dump_data  = OMDR;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign core_OMDR = OMDR;
    assign neg_flag  = neg_q;

endmodule
